// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS word width, control tokens and receive FSM states shared by the TMDS blocks.
package tmds_pkg;
  localparam int TMDS_W = 10;
  localparam logic [TMDS_W-1:0] CTRL_00 = 10'h354;
  localparam logic [TMDS_W-1:0] CTRL_01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] CTRL_10 = 10'h154;
  localparam logic [TMDS_W-1:0] CTRL_11 = 10'h2AB;
  typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} state_t;
endpackage

// File: rtl/tmds_char_decode.sv
// tmds_char_decode: combinational TMDS character decode into {de, control code, pixel byte}.
module tmds_char_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_W-1:0] q,
  output logic              de,
  output logic [1:0]        c,
  output logic [7:0]        data
);
  logic [7:0] t;
  always_comb begin
    t = q[9] ? ~q[7:0] : q[7:0];
    de = !(q == CTRL_00 || q == CTRL_01 || q == CTRL_10 || q == CTRL_11);
    c = q == CTRL_01 ? 2'b01 : q == CTRL_10 ? 2'b10 : q == CTRL_11 ? 2'b11 : 2'b00;
    data = {t[7:1] ^ t[6:0] ^ {7{~q[8]}}, t[0]};
  end
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS lane receiver with token-based word alignment and decode.
// Define TMDS_ERR_CNT_EN to add the saturating lock_loss_cnt_o counter port.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN = 8,
  parameter int TIMEOUT  = 2048
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic [TMDS_W-1:0] data_i,
  output logic [7:0]        data_o,
  output logic [1:0]        c_o,
  output logic              de_o,
  output logic              locked_o,
  output logic [3:0]        offset_o
`ifdef TMDS_ERR_CNT_EN
  ,
  output logic [15:0]       lock_loss_cnt_o
`endif
);
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TW = $clog2(TIMEOUT);
  logic [TMDS_W-1:0] prev_q, win_q, win;
  logic [RW-1:0] run_cnt;
  logic [TW-1:0] tmo_cnt;
  logic settle;
  state_t state;
  logic dec_de, run_full, tmo_full, step, lock;
  logic [1:0] dec_c;
  logic [7:0] dec_data;
  logic [3:0] offset_nxt;

  tmds_char_decode u_dec (.q(win_q), .de(dec_de), .c(dec_c), .data(dec_data));

  always_comb begin
    win = TMDS_W'({data_i, prev_q} >> offset_o);
    lock = state == LOCKED;
    run_full = run_cnt == RW'(CTRL_RUN);
    tmo_full = tmo_cnt == TW'(TIMEOUT - 1);
    // a completed token run always beats a simultaneous timeout
    step = state != SETTLE && tmo_full && !run_full;
    offset_nxt = offset_o == 4'd9 ? 4'd0 : offset_o + 4'd1;
  end

  assign locked_o = lock;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      prev_q <= '0;
      win_q <= '0;
      data_o <= '0;
      c_o <= '0;
      de_o <= 1'b0;
      offset_o <= '0;
      run_cnt <= '0;
      tmo_cnt <= '0;
      settle <= 1'b0;
      state <= SEARCH;
    end else begin
      prev_q <= data_i;
      win_q <= win;
      data_o <= lock && dec_de ? dec_data : 8'd0;
      c_o <= lock && !dec_de ? dec_c : 2'b00;
      de_o <= lock && dec_de;
      run_cnt <= state == SETTLE || step || dec_de ? '0 : run_full ? run_cnt : run_cnt + RW'(1);
      tmo_cnt <= state == SETTLE || step || run_full ? '0 : tmo_cnt + TW'(1);
      if (state == SETTLE) begin
        settle <= !settle;
        if (settle) state <= SEARCH;
      end else if (step) begin
        state <= SETTLE;
        offset_o <= offset_nxt;
      end else if (run_full) state <= LOCKED;
    end
  end

`ifdef TMDS_ERR_CNT_EN
  always_ff @(posedge clk_pix) begin
    if (rst) lock_loss_cnt_o <= '0;
    else if (step && lock && lock_loss_cnt_o != 16'hFFFF) lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed vectors for lock, bit-slip search, decode, lock loss and reset.
module tb_tmds_channel_decoder;
  logic clk_pix = 1'b0;
  logic rst = 1'b1;
  logic [9:0] data_i = '0;
  logic [7:0] data_o;
  logic [1:0] c_o;
  logic de_o, locked_o;
  logic [3:0] offset_o;
`ifdef TMDS_ERR_CNT_EN
  logic [15:0] lock_loss_cnt_o;
`endif
  int n_vec = 0, n_bad = 0;
  int sh = 0, n = 0;
  logic [9:0] last = '0;
  logic [3:0] last_off = '0;
  logic [3:0] offs[$];

  tmds_channel_decoder dut (
    .clk_pix(clk_pix), .rst(rst), .data_i(data_i), .data_o(data_o), .c_o(c_o),
    .de_o(de_o), .locked_o(locked_o), .offset_o(offset_o)
`ifdef TMDS_ERR_CNT_EN
    , .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  always @(negedge clk_pix)
    if (offset_o !== last_off) begin
      offs.push_back(offset_o);
      last_off = offset_o;
    end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // character ch is placed on the wire sh bits into the word, as a misaligned deserializer would see it
  task automatic put(input logic [9:0] ch);
    logic [19:0] cat;
    cat = {ch, last} >> (10 - sh);
    data_i = cat[9:0];
    last = ch;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic do_reset(input int shift);
    rst = 1'b1;
    sh = 0;
    last = '0;
    put(10'h0);
    put(10'h0);
    rst = 1'b0;
    sh = shift;
  endtask

  task automatic run_until(input logic [9:0] ch, input logic want, input int bound);
    n = 0;
    do begin
      put(ch);
      n++;
    end while (locked_o !== want && n < bound);
  endtask

  task automatic xfer(input string tag, input logic [9:0] ch, input logic de, input logic [1:0] c, input logic [7:0] d);
    put(ch);
    put(10'h354);
    put(10'h354);
    chk({tag, "_de"}, 16'(de_o), 16'(de));
    chk({tag, "_c"}, 16'(c_o), 16'(c));
    chk({tag, "_data"}, 16'(data_o), 16'(d));
  endtask

  initial begin
    do_reset(0);
    chk("rst_data", 16'(data_o), 16'h0);
    chk("rst_c", 16'(c_o), 16'h0);
    chk("rst_de", 16'(de_o), 16'h0);
    chk("rst_lock", 16'(locked_o), 16'h0);
    chk("rst_off", 16'(offset_o), 16'h0);
    for (int i = 1; i <= 11; i++) begin
      put(10'h354);
      if (i == 10) chk("lock_early", 16'(locked_o), 16'h0);
      if (i == 11) chk("lock_at", 16'(locked_o), 16'h1);
    end
    put(10'h354);
    chk("tok00_c", 16'(c_o), 16'h0);
    chk("tok00_de", 16'(de_o), 16'h0);
    xfer("tok01", 10'h0AB, 1'b0, 2'b01, 8'h00);
    xfer("tok10", 10'h154, 1'b0, 2'b10, 8'h00);
    xfer("tok11", 10'h2AB, 1'b0, 2'b11, 8'h00);
    xfer("d100", 10'h100, 1'b1, 2'b00, 8'h00);
    xfer("d200", 10'h200, 1'b1, 2'b00, 8'hFF);
    xfer("d1ff", 10'h1FF, 1'b1, 2'b00, 8'h01);
    xfer("d3f0", 10'h3F0, 1'b1, 2'b00, 8'h11);
    // saturate the token run so the timeout starts from a known point
    repeat (10) put(10'h354);
    run_until(10'h100, 1'b0, 3000);
    chk("tmo_cycles", 16'(n), 16'd2051);
    chk("tmo_lock", 16'(locked_o), 16'h0);
    chk("tmo_off", 16'(offset_o), 16'h1);

    do_reset(3);
    offs.delete();
    for (int l = 0; l < 12 && !locked_o; l++)
      for (int i = 0; i < 800 && !locked_o; i++) put(i < 16 ? 10'h354 : 10'h100);
    chk("sh3_lock", 16'(locked_o), 16'h1);
    chk("sh3_off", 16'(offset_o), 16'h3);
    chk("sh3_nsteps", 16'(offs.size()), 16'd3);
    chk("sh3_step0", 16'(offs[0]), 16'h1);
    chk("sh3_step1", 16'(offs[1]), 16'h2);
    chk("sh3_step2", 16'(offs[2]), 16'h3);
    xfer("sh3_d200", 10'h200, 1'b1, 2'b00, 8'hFF);
    xfer("sh3_tok01", 10'h0AB, 1'b0, 2'b01, 8'h00);
    xfer("sh3_d3f0", 10'h3F0, 1'b1, 2'b00, 8'h11);

    do_reset(9);
    run_until(10'h354, 1'b1, 25000);
    chk("sh9_lock", 16'(locked_o), 16'h1);
    chk("sh9_off", 16'(offset_o), 16'h9);
    run_until(10'h100, 1'b0, 3000);
    chk("wrap_lock", 16'(locked_o), 16'h0);
    chk("wrap_off", 16'(offset_o), 16'h0);

    do_reset(5);
    run_until(10'h354, 1'b1, 15000);
    chk("sh5_lock", 16'(locked_o), 16'h1);
    chk("sh5_off", 16'(offset_o), 16'h5);
    xfer("sh5_d200", 10'h200, 1'b1, 2'b00, 8'hFF);
    rst = 1'b1;
    put(10'h354);
    rst = 1'b0;
    chk("mid_rst_data", 16'(data_o), 16'h0);
    chk("mid_rst_de", 16'(de_o), 16'h0);
    chk("mid_rst_c", 16'(c_o), 16'h0);
    chk("mid_rst_lock", 16'(locked_o), 16'h0);
    chk("mid_rst_off", 16'(offset_o), 16'h0);

`ifdef TMDS_ERR_CNT_EN
    do_reset(0);
    chk("errcnt_rst", lock_loss_cnt_o, 16'd0);
    run_until(10'h354, 1'b1, 100);
    for (int o = 1; o <= 3; o++) begin
      run_until(10'h100, 1'b0, 3000);
      chk("errcnt_step", lock_loss_cnt_o, 16'(o));
      sh = o;
      run_until(10'h354, 1'b1, 3000);
      chk("errcnt_relock", 16'(locked_o), 16'h1);
    end
    chk("errcnt_final", lock_loss_cnt_o, 16'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
